// File: rtl/fc_acc_pkg.sv
// Shared types and helpers for the FC partial-sum accumulator.
//   state_t    : top-level controller states
//   *_DEF      : default parameter values used by the top and the bench
//   sat_signed : clamp a wide signed value to a w-bit signed range
package fc_acc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_OUT,
        S_DRAIN
    } state_t;

    localparam int PSUM_W_DEF    = 8;
    localparam int ACC_W_DEF     = 32;
    localparam int OUT_W_DEF     = 8;
    localparam int MAX_NODES_DEF = 1024;
    localparam int TILE_W_DEF    = 8;
    localparam int SHIFT_W_DEF   = 5;

    // Clamp v to [-2^(w-1), 2^(w-1)-1]. The return value is still 64 bits wide.
    // The caller keeps the low w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                       input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational requantiser. It maps an ACC_W accumulator to an OUT_W result in three steps:
// a rounding arithmetic right shift (round half up), an optional ReLU, and then saturation.
//   acc     : signed accumulator value
//   shift   : right-shift amount. A value of 0 passes acc through unchanged.
//   relu_en : when set, negative values become 0
//   result  : saturated signed result
module fc_requant
    import fc_acc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [OUT_W-1:0]   result
);

    // The calculation uses one extra bit, so adding the rounding bias cannot overflow.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] shifted;
    logic signed [63:0]    wide;
    logic signed [63:0]    clamped;

    always_comb begin
        ext  = {acc[ACC_W-1], acc};
        bias = '0;
        if (shift != '0) begin
            bias = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        shifted = (ext + bias) >>> shift;
        wide    = {{(63-ACC_W){shifted[ACC_W]}}, shifted};
        if (relu_en && (wide < 0)) begin
            wide = '0;
        end
        clamped = sat_signed(wide, OUT_W);
        result  = OUT_W'(clamped);
    end

endmodule

// File: rtl/simple_dual_one_clock.sv
// Simple dual-port block RAM. Port A writes and port B reads. Both ports use one clock.
//   clk   : clock
//   ena   : port A enable
//   wea   : port A write enable
//   addra : write address
//   dia   : write data
//   enb   : port B read enable
//   addrb : read address
//   dob   : registered read data. It is valid one cycle after enb.
// If a read and a write hit the same address in the same cycle, the read returns the old contents.
module simple_dual_one_clock #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     ena,
    input  logic                     enb,
    input  logic                     wea,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    input  logic [WIDTH-1:0]         dia,
    output logic [WIDTH-1:0]         dob
);

    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            ram[addra] <= dia;
        end
    end

    always_ff @(posedge clk) begin
        if (enb) begin
            dob <= ram[addrb];
        end
    end

endmodule

// File: rtl/fc_accumulator_pq.sv
// FC partial-sum accumulator for one systolic-array column.
// Psums arrive in node order 0..N-1, once per tile. Each psum is added into a per-node
// SRAM word through a 2-stage read-modify-write pipe. After the last tile, each node is
// read back, requantised, and streamed out through a 2-entry skid buffer that supports
// ready/valid backpressure.
//   clk, rst        : clock and synchronous active-high reset
//   psum_i/pvalid_i : psum input. It is accepted while psum_ready_o is 1.
//   out_node_num_i, tile_num_i, shift_i, relu_en_i : layer configuration, sampled on the first psum
//   fc_valid_o/fc_ready_i/fc_result_o/last_o : result stream. last_o marks node N-1.
//   err_o           : sticky error. It is set by a zero config or by a psum sent while not ready.
module fc_accumulator_pq
    import fc_acc_pkg::*;
#(
    parameter int PSUM_W    = PSUM_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int MAX_NODES = MAX_NODES_DEF,
    parameter int TILE_W    = TILE_W_DEF,
    parameter int SHIFT_W   = SHIFT_W_DEF,
    parameter int NODE_W    = $clog2(MAX_NODES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PSUM_W-1:0]  psum_i,
    input  logic               pvalid_i,
    output logic               psum_ready_o,
    input  logic [NODE_W:0]    out_node_num_i,
    input  logic [TILE_W-1:0]  tile_num_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_en_i,
    output logic               fc_valid_o,
    input  logic               fc_ready_i,
    output logic [OUT_W-1:0]   fc_result_o,
    output logic               last_o,
    output logic               err_o
);

    state_t              state_reg;
    logic [NODE_W-1:0]   node_cnt_reg;
    logic [TILE_W-1:0]   tile_cnt_reg;
    logic [NODE_W:0]     n_cfg_reg;
    logic [TILE_W-1:0]   t_cfg_reg;
    logic [SHIFT_W-1:0]  shift_cfg_reg;
    logic                relu_cfg_reg;
    logic                err_reg;

    // Stage c1 of the read-modify-write pipe.
    logic                c1_valid_reg;
    logic [PSUM_W-1:0]   c1_psum_reg;
    logic [NODE_W-1:0]   c1_node_reg;
    logic                c1_first_reg;
    logic                fwd_sel_reg;
    logic [ACC_W-1:0]    fwd_data_reg;

    // Output read pipe and skid buffer.
    logic                rd_pending_reg;
    logic                rd_last_reg;
    logic [1:0]          count_reg;
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [OUT_W-1:0]    skid_data [2];
    logic                skid_last [2];

    logic                psum_ready;
    logic                accept;
    logic                cfg_zero;
    logic [NODE_W:0]     n_eff;
    logic [TILE_W-1:0]   t_eff;
    logic                node_last;
    logic                tile_last;
    logic                out_node_last;
    logic                pop;
    logic                push;
    logic                issue;
    logic [2:0]          occ_after;
    logic [ACC_W-1:0]    sram_dout;
    logic [ACC_W-1:0]    operand;
    logic [ACC_W-1:0]    sum;
    logic [OUT_W-1:0]    rq_result;

    assign psum_ready = (state_reg == S_IDLE) || (state_reg == S_ACC);
    assign accept     = pvalid_i && psum_ready;
    assign cfg_zero   = (out_node_num_i == '0) || (tile_num_i == '0);

    // In idle, the first psum of a layer supplies the configuration directly.
    // A zero count is treated as 1.
    always_comb begin
        n_eff = n_cfg_reg;
        t_eff = t_cfg_reg;
        if (state_reg == S_IDLE) begin
            n_eff = (out_node_num_i == '0) ? (NODE_W+1)'(1) : out_node_num_i;
            t_eff = (tile_num_i == '0) ? TILE_W'(1) : tile_num_i;
        end
    end

    assign node_last     = ({1'b0, node_cnt_reg} == (n_eff - (NODE_W+1)'(1)));
    assign tile_last     = (tile_cnt_reg == (t_eff - TILE_W'(1)));
    assign out_node_last = ({1'b0, node_cnt_reg} == (n_cfg_reg - (NODE_W+1)'(1)));

    // A read is issued only if its data will find a free slot when it returns.
    // occ_after is the buffer occupancy at the end of this cycle. A read issued now
    // pushes one cycle later, so that occupancy must be at most 1.
    assign pop       = (count_reg != 2'd0) && fc_ready_i;
    assign push      = rd_pending_reg;
    assign occ_after = {1'b0, count_reg} - {2'b00, pop} + {2'b00, rd_pending_reg};
    assign issue     = (state_reg == S_OUT) && (occ_after < 3'd2);

    // Forwarding: a read in c0 that collides with the write in c1 gets stale SRAM data.
    // In that case c1 uses the sum registered in the previous cycle.
    assign operand = fwd_sel_reg ? fwd_data_reg : sram_dout;
    assign sum     = {{(ACC_W-PSUM_W){c1_psum_reg[PSUM_W-1]}}, c1_psum_reg}
                   + (c1_first_reg ? '0 : operand);

    // A single read address serves both phases.
    // It is the accumulate node in S_IDLE/S_ACC and the output node in S_OUT.
    simple_dual_one_clock #(
        .DEPTH (MAX_NODES),
        .WIDTH (ACC_W)
    ) u_sram (
        .clk   (clk),
        .ena   (c1_valid_reg),
        .enb   (accept || issue),
        .wea   (c1_valid_reg),
        .addra (c1_node_reg),
        .addrb (node_cnt_reg),
        .dia   (sum),
        .dob   (sram_dout)
    );

    fc_requant #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .acc     (sram_dout),
        .shift   (shift_cfg_reg),
        .relu_en (relu_cfg_reg),
        .result  (rq_result)
    );

    // Skid buffer entries. An entry is written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            logic [OUT_W-1:0] data_reg;
            logic             last_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= rq_result;
                    last_reg <= rd_last_reg;
                end
            end
            assign skid_data[gi] = data_reg;
            assign skid_last[gi] = last_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            node_cnt_reg   <= '0;
            tile_cnt_reg   <= '0;
            n_cfg_reg      <= (NODE_W+1)'(1);
            t_cfg_reg      <= TILE_W'(1);
            shift_cfg_reg  <= '0;
            relu_cfg_reg   <= 1'b0;
            err_reg        <= 1'b0;
            c1_valid_reg   <= 1'b0;
            c1_psum_reg    <= '0;
            c1_node_reg    <= '0;
            c1_first_reg   <= 1'b0;
            fwd_sel_reg    <= 1'b0;
            fwd_data_reg   <= '0;
            rd_pending_reg <= 1'b0;
            rd_last_reg    <= 1'b0;
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
        end else begin
            c1_valid_reg   <= accept;
            c1_psum_reg    <= psum_i;
            c1_node_reg    <= node_cnt_reg;
            c1_first_reg   <= (tile_cnt_reg == '0);
            fwd_sel_reg    <= accept && c1_valid_reg && (c1_node_reg == node_cnt_reg);
            fwd_data_reg   <= sum;

            rd_pending_reg <= issue;
            rd_last_reg    <= issue && out_node_last;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};

            if (pvalid_i && !psum_ready) begin
                err_reg <= 1'b1;
            end

            if ((state_reg == S_IDLE) && accept) begin
                n_cfg_reg     <= n_eff;
                t_cfg_reg     <= t_eff;
                shift_cfg_reg <= shift_i;
                relu_cfg_reg  <= relu_en_i;
                if (cfg_zero) begin
                    err_reg <= 1'b1;
                end
            end

            if (accept) begin
                if (node_last) begin
                    node_cnt_reg <= '0;
                    if (tile_last) begin
                        tile_cnt_reg <= '0;
                        state_reg    <= S_FLUSH;
                    end else begin
                        tile_cnt_reg <= tile_cnt_reg + TILE_W'(1);
                        state_reg    <= S_ACC;
                    end
                end else begin
                    node_cnt_reg <= node_cnt_reg + NODE_W'(1);
                    state_reg    <= S_ACC;
                end
            end

            case (state_reg)
                S_FLUSH: state_reg <= S_OUT;
                S_OUT: begin
                    if (issue) begin
                        if (out_node_last) begin
                            node_cnt_reg <= '0;
                            state_reg    <= S_DRAIN;
                        end else begin
                            node_cnt_reg <= node_cnt_reg + NODE_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && skid_last[rd_ptr_reg]) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign psum_ready_o = psum_ready;
    assign fc_valid_o   = (count_reg != 2'd0);
    assign fc_result_o  = skid_data[rd_ptr_reg];
    assign last_o       = fc_valid_o && skid_last[rd_ptr_reg];
    assign err_o        = err_reg;

endmodule

// File: tb/tb_fc_accumulator_pq.sv
// Directed bench for fc_accumulator_pq.
// Every accepted result is logged on its own line, and every expected value is computed here.
module tb_fc_accumulator_pq;

    localparam int PSUM_W  = 8;
    localparam int OUT_W   = 8;
    localparam int TILE_W  = 8;
    localparam int SHIFT_W = 5;
    localparam int NODE_W  = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PSUM_W-1:0]  psum_i = '0;
    logic               pvalid_i = 1'b0;
    logic               psum_ready_o;
    logic [NODE_W:0]    out_node_num_i = '0;
    logic [TILE_W-1:0]  tile_num_i = '0;
    logic [SHIFT_W-1:0] shift_i = '0;
    logic               relu_en_i = 1'b0;
    logic               fc_valid_o;
    logic               fc_ready_i;
    logic [OUT_W-1:0]   fc_result_o;
    logic               last_o;
    logic               err_o;

    fc_accumulator_pq dut (
        .clk            (clk),
        .rst            (rst),
        .psum_i         (psum_i),
        .pvalid_i       (pvalid_i),
        .psum_ready_o   (psum_ready_o),
        .out_node_num_i (out_node_num_i),
        .tile_num_i     (tile_num_i),
        .shift_i        (shift_i),
        .relu_en_i      (relu_en_i),
        .fc_valid_o     (fc_valid_o),
        .fc_ready_i     (fc_ready_i),
        .fc_result_o    (fc_result_o),
        .last_o         (last_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Downstream ready generator. It drives all-ones, or the 1,0,0,1 pattern when ready_mode is set.
    bit ready_mode = 1'b0;
    int rcyc = 0;
    initial begin
        fc_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                fc_ready_i = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
                rcyc++;
            end else begin
                fc_ready_i = 1'b1;
            end
        end
    end

    // Output monitor. It samples on the falling edge.
    int               got_val[$];
    bit               got_last[$];
    int               got_cyc[$];
    int               first_valid_cyc = -1;
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] held_res;
    logic             held_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", longint'({fc_valid_o, last_o, fc_result_o}),
                      longint'({1'b1, held_last, held_res}));
            if (fc_valid_o && (first_valid_cyc < 0)) first_valid_cyc = cyc;
            if (fc_valid_o && fc_ready_i) begin
                got_val.push_back(int'($signed(fc_result_o)));
                got_last.push_back(last_o);
                got_cyc.push_back(cyc);
                $display("result %0d: value %0d last %0b cycle %0d",
                         got_val.size() - 1, $signed(fc_result_o), last_o, cyc);
            end
            stall_prev = fc_valid_o && !fc_ready_i;
            held_res   = fc_result_o;
            held_last  = last_o;
        end
    end

    int stim_q[$];
    int exp_q[$];
    int last_acc_cyc = 0;

    task automatic do_reset();
        rst = 1'b1;
        pvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, fc_valid_o, 0);
        check({name, "_last"}, last_o, 0);
        check({name, "_result"}, fc_result_o, 0);
        check({name, "_err"}, err_o, 0);
        check({name, "_ready"}, psum_ready_o, 1);
    endtask

    task automatic send_psum(input int v);
        int w = 0;
        psum_i   = PSUM_W'(v);
        pvalid_i = 1'b1;
        while (!psum_ready_o && (w < 200)) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("send_ready", psum_ready_o, 1);
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
    endtask

    task automatic run_layer(input string name, input int n, input int t, input int s,
                             input bit relu, input bit poke);
        int w = 0;
        got_val.delete();
        got_last.delete();
        got_cyc.delete();
        first_valid_cyc = -1;
        out_node_num_i  = (NODE_W+1)'(n);
        tile_num_i      = TILE_W'(t);
        shift_i         = SHIFT_W'(s);
        relu_en_i       = relu;
        foreach (stim_q[i]) send_psum(stim_q[i]);
        if (poke) begin
            // These psums arrive while the block is not ready. They must be dropped.
            psum_i   = 8'd99;
            pvalid_i = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        pvalid_i = 1'b0;
        while ((got_val.size() < exp_q.size()) && (w < 3000)) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({name, "_count"}, got_val.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_val.size()) begin
                check($sformatf("%s_res%0d", name, i), got_val[i], exp_q[i]);
                check($sformatf("%s_last%0d", name, i), got_last[i], (i == exp_q.size() - 1));
            end
        end
        check({name, "_idle_ready"}, psum_ready_o, 1);
        check({name, "_idle_valid"}, fc_valid_o, 0);
    endtask

    function automatic int model(input longint acc, input int s, input bit relu);
        longint v;
        v = acc;
        if (s > 0) v = (acc + (longint'(1) << (s - 1))) >>> s;
        if (relu && (v < 0)) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    initial begin
        longint acc[8];
        int     v;

        do_reset();
        check_reset_state("reset");

        // Basic pass-through, with output timing checks.
        stim_q = '{1, 2, 3, -4};
        exp_q  = '{1, 2, 3, -4};
        run_layer("n4t1", 4, 1, 0, 0, 0);
        check("n4t1_first_latency", first_valid_cyc - last_acc_cyc, 3);
        for (int i = 1; i < got_cyc.size(); i++)
            check($sformatf("n4t1_gap%0d", i), got_cyc[i] - got_cyc[i-1], 1);
        check("n4t1_err", err_o, 0);

        // Back-to-back updates to one node exercise the forwarding path.
        stim_q = '{100, 100, 100};
        exp_q  = '{127};
        run_layer("fwd_s0", 1, 3, 0, 0, 0);
        exp_q  = '{75};
        run_layer("fwd_s2", 1, 3, 2, 0, 0);

        stim_q = '{-5, 10, 0, -3, 20, 1};
        exp_q  = '{0, 30, 1};
        run_layer("relu", 3, 2, 0, 1, 0);

        stim_q = '{-128, -128, -128, -128};
        exp_q  = '{-128, -128};
        run_layer("negsat", 2, 2, 0, 0, 0);

        stim_q = '{-6};
        exp_q  = '{-1};
        run_layer("round", 1, 1, 2, 0, 0);
        check("directed_err", err_o, 0);

        // Random psums with downstream backpressure.
        stim_q.delete();
        exp_q.delete();
        for (int n = 0; n < 8; n++) acc[n] = 0;
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 8; n++) begin
                v = int'($urandom_range(0, 255)) - 128;
                stim_q.push_back(v);
                acc[n] += v;
            end
        end
        for (int n = 0; n < 8; n++) exp_q.push_back(model(acc[n], 1, 1'b0));
        ready_mode = 1'b1;
        run_layer("rand", 8, 4, 1, 0, 0);
        ready_mode = 1'b0;

        // A reset in the middle of accumulation aborts the layer. The next layer starts clean.
        out_node_num_i = 11'd4;
        tile_num_i     = 8'd2;
        shift_i        = '0;
        relu_en_i      = 1'b0;
        send_psum(50);
        send_psum(50);
        send_psum(50);
        do_reset();
        check_reset_state("midrst");
        stim_q = '{5, 6};
        exp_q  = '{5, 6};
        run_layer("resume", 2, 1, 0, 0, 0);
        check("resume_err", err_o, 0);

        // A psum sent while the block is busy is dropped and sets the sticky error.
        stim_q = '{7, 8};
        exp_q  = '{7, 8};
        run_layer("drop", 2, 1, 0, 0, 1);
        check("drop_err", err_o, 1);

        // A zero config is treated as N=1, T=1 and raises the error flag.
        do_reset();
        check("cfg0_err_pre", err_o, 0);
        stim_q = '{9};
        exp_q  = '{9};
        run_layer("cfg0", 0, 0, 0, 0, 0);
        check("cfg0_err", err_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
